// File: rtl/point_frame_buffer.sv
// Double-buffered point store: a byte stream is synced, assembled into points and
// written into one bank while a renderer reads the other; banks swap at frame end.
module point_frame_buffer #(
  parameter int DEPTH       = 2000,
  parameter int ADDR_W      = 11,
  parameter int COORD_W     = 12,
  parameter int BRIGHT_W    = 6,
  parameter int POINT_BYTES = 4,
  parameter int SYNC_LEN    = 8,
  parameter int TIMEOUT     = 100000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  input  logic                              done_drawing,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [2*COORD_W+BRIGHT_W-1:0]     rd_point,
  output logic [ADDR_W-1:0]                 num_points,
  output logic                              drawing,
  output logic                              overflow,
  output logic                              frame_drop
);

  localparam int DATA_W = 2*COORD_W + BRIGHT_W;
  localparam int WORD_W = 8*POINT_BYTES;
  localparam int BIDX_W = (POINT_BYTES > 1) ? $clog2(POINT_BYTES) : 1;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [WORD_W-1:0] END_MARK = {POINT_BYTES{8'h01}};

  typedef enum logic [1:0] {WAIT_SYNC, RECV, DONE} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0]   bank0 [DEPTH];
  logic [DATA_W-1:0]   bank1 [DEPTH];
  logic                wr_bank;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [7:0]          zero_cnt;
  logic [BIDX_W-1:0]   byte_idx;
  logic [TO_W-1:0]     to_cnt;
  logic [WORD_W-9:0]   word_sr;

  logic [WORD_W-1:0]   word_full;
  logic                last_byte, sync_hit, point_done, is_end, has_room;
  logic                mem_we, drop_pt, idle_to, do_swap;

  // The incoming byte completes the word combinationally so the last byte is acted on in its own cycle.
  always_comb begin
    word_full  = {word_sr, in_data};
    last_byte  = (byte_idx == BIDX_W'(POINT_BYTES-1));
    sync_hit   = (state == WAIT_SYNC) && in_valid && (in_data == 8'h00) &&
                 (zero_cnt == 8'(SYNC_LEN-1));
    point_done = (state == RECV) && in_valid && last_byte;
    is_end     = point_done && (word_full == END_MARK);
    has_room   = (wr_ptr < ADDR_W'(DEPTH));
    mem_we     = point_done && !is_end && has_room;
    drop_pt    = point_done && !is_end && !has_room;
    idle_to    = (state == RECV) && !in_valid && (to_cnt == TO_W'(TIMEOUT-1));
    do_swap    = (state == DONE) && !drawing;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (sync_hit) state_next = RECV;
      RECV: begin
        if (is_end)       state_next = DONE;
        else if (idle_to) state_next = WAIT_SYNC;
      end
      DONE:      if (do_swap) state_next = WAIT_SYNC;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      zero_cnt   <= '0;
      byte_idx   <= '0;
      to_cnt     <= '0;
      word_sr    <= '0;
      num_points <= '0;
      drawing    <= 1'b0;
      overflow   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      overflow   <= drop_pt;
      frame_drop <= idle_to;
      case (state)
        WAIT_SYNC: begin
          if (in_valid) begin
            if (sync_hit) begin
              zero_cnt <= '0;
              wr_ptr   <= '0;
              byte_idx <= '0;
              to_cnt   <= '0;
            end else if (in_data == 8'h00) begin
              zero_cnt <= zero_cnt + 8'd1;
            end else begin
              zero_cnt <= '0;
            end
          end
        end
        RECV: begin
          if (in_valid) begin
            to_cnt   <= '0;
            word_sr  <= word_full[WORD_W-9:0];
            byte_idx <= last_byte ? '0 : byte_idx + BIDX_W'(1);
            if (mem_we) wr_ptr <= wr_ptr + ADDR_W'(1);
          end else if (!idle_to) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE: begin
          if (do_swap) begin
            wr_bank    <= ~wr_bank;
            num_points <= wr_ptr;
            drawing    <= 1'b1;
          end
        end
        default: ;
      endcase
      // Releasing the read bank is only honoured once a new frame is waiting.
      if ((state == DONE) && drawing && done_drawing) drawing <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (wr_bank) bank1[wr_ptr[MEM_AW-1:0]] <= word_full[DATA_W-1:0];
      else         bank0[wr_ptr[MEM_AW-1:0]] <= word_full[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_point <= '0;
    end else if (rd_addr < ADDR_W'(DEPTH)) begin
      rd_point <= wr_bank ? bank0[rd_addr[MEM_AW-1:0]] : bank1[rd_addr[MEM_AW-1:0]];
    end else begin
      rd_point <= '0;
    end
  end

endmodule

// File: tb/tb_point_frame_buffer.sv
// Bench for point_frame_buffer: a full-depth and a 4-deep instance share one input stream.
module tb_point_frame_buffer;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        done_drawing = 1'b0;
  logic [10:0] rd_addr = '0;

  logic [29:0] rd_point_a, rd_point_b;
  logic [10:0] num_points_a, num_points_b;
  logic        drawing_a, drawing_b, overflow_a, overflow_b, frame_drop_a, frame_drop_b;

  point_frame_buffer #(.TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .done_drawing(done_drawing), .rd_addr(rd_addr), .rd_point(rd_point_a),
    .num_points(num_points_a), .drawing(drawing_a), .overflow(overflow_a),
    .frame_drop(frame_drop_a));

  point_frame_buffer #(.DEPTH(4), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .done_drawing(done_drawing), .rd_addr(rd_addr), .rd_point(rd_point_b),
    .num_points(num_points_b), .drawing(drawing_b), .overflow(overflow_b),
    .frame_drop(frame_drop_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_a = 0, ovf_b = 0, fd_a = 0, fd_b = 0;

  always @(negedge clk) begin
    if (overflow_a === 1'b1)   ovf_a++;
    if (overflow_b === 1'b1)   ovf_b++;
    if (frame_drop_a === 1'b1) fd_a++;
    if (frame_drop_b === 1'b1) fd_b++;
  end

  typedef struct {
    int          phase;
    logic [10:0] addr;
    logic [29:0] exp_a;
    logic [29:0] exp_b;
    bit          chk_b;
  } rd_vec_t;

  rd_vec_t tbl[$];
  rd_vec_t sbq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) send_byte(8'h00);
  endtask

  task automatic pulse_done();
    done_drawing = 1'b1;
    tick();
    done_drawing = 1'b0;
  endtask

  task automatic run_reads(input int p);
    rd_vec_t e;
    foreach (tbl[i]) begin
      if (tbl[i].phase == p) begin
        rd_addr = tbl[i].addr;
        sbq.push_back(tbl[i]);
        tick();
        e = sbq.pop_front();
        chk($sformatf("p%0d_rd_a[%0d]", p, e.addr), {2'b00, rd_point_a}, {2'b00, e.exp_a});
        if (e.chk_b)
          chk($sformatf("p%0d_rd_b[%0d]", p, e.addr), {2'b00, rd_point_b}, {2'b00, e.exp_b});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_point_a"}, {2'b00, rd_point_a}, 32'd0);
    chk({tag, "_rd_point_b"}, {2'b00, rd_point_b}, 32'd0);
    chk({tag, "_num_points_a"}, {21'd0, num_points_a}, 32'd0);
    chk({tag, "_num_points_b"}, {21'd0, num_points_b}, 32'd0);
    chk({tag, "_drawing"}, {30'd0, drawing_a, drawing_b}, 32'd0);
    chk({tag, "_overflow"}, {30'd0, overflow_a, overflow_b}, 32'd0);
    chk({tag, "_frame_drop"}, {30'd0, frame_drop_a, frame_drop_b}, 32'd0);
  endtask

  logic [31:0] pts [6];
  int base_a, base_b;

  initial begin
    pts = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314, 32'h15161718};
    tbl.push_back('{1, 11'd0, 30'h3F123456, 30'h3F123456, 1'b1});
    tbl.push_back('{1, 11'd1, 30'h00ABCDEF, 30'h00ABCDEF, 1'b1});
    tbl.push_back('{2, 11'd0, 30'h00000777, 30'h00000777, 1'b1});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{3, 11'(i), pts[i][29:0], pts[i][29:0], (i < 4)});
    tbl.push_back('{5, 11'd0, 30'h2ABCDEF0, 30'h2ABCDEF0, 1'b1});
    tbl.push_back('{5, 11'd1, 30'h00000001, 30'h00000001, 1'b1});

    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Basic frame: swap happens one cycle after the end marker
    send_sync();
    send_word(32'h3F123456);
    send_word(32'h00ABCDEF);
    send_word(32'h01010101);
    chk("p1_drawing_before_swap", {31'd0, drawing_a}, 32'd0);
    tick();
    chk("p1_drawing_a", {31'd0, drawing_a}, 32'd1);
    chk("p1_drawing_b", {31'd0, drawing_b}, 32'd1);
    chk("p1_num_points_a", {21'd0, num_points_a}, 32'd2);
    chk("p1_num_points_b", {21'd0, num_points_b}, 32'd2);
    run_reads(1);

    // Broken sync then real sync; frame held back while drawing
    for (int i = 0; i < 7; i++) send_byte(8'h00);
    send_byte(8'h05);
    send_sync();
    send_word(32'h00000777);
    send_word(32'h01010101);
    tick();
    chk("p2_held_drawing", {31'd0, drawing_a}, 32'd1);
    chk("p2_held_num_points", {21'd0, num_points_a}, 32'd2);
    chk("p2_held_rd_point", {2'b00, rd_point_a}, 32'h00ABCDEF);
    pulse_done();
    chk("p2_drawing_cleared", {31'd0, drawing_a}, 32'd0);
    chk("p2_num_points_pre_swap", {21'd0, num_points_a}, 32'd2);
    tick();
    chk("p2_drawing_set", {31'd0, drawing_a}, 32'd1);
    chk("p2_num_points_a", {21'd0, num_points_a}, 32'd1);
    chk("p2_num_points_b", {21'd0, num_points_b}, 32'd1);
    run_reads(2);
    pulse_done();
    tick();
    chk("p2_redraw_drawing", {30'd0, drawing_a, drawing_b}, 32'd3);

    // Six points into a 4-deep bank
    base_a = ovf_a;
    base_b = ovf_b;
    send_sync();
    for (int i = 0; i < 6; i++) send_word(pts[i]);
    send_word(32'h01010101);
    tick();
    chk("p3_num_points_pre_swap", {21'd0, num_points_a}, 32'd1);
    pulse_done();
    tick();
    chk("p3_overflow_a", ovf_a - base_a, 32'd0);
    chk("p3_overflow_b", ovf_b - base_b, 32'd2);
    chk("p3_num_points_a", {21'd0, num_points_a}, 32'd6);
    chk("p3_num_points_b", {21'd0, num_points_b}, 32'd4);
    run_reads(3);

    // Timeout inside a point
    base_a = fd_a;
    base_b = fd_b;
    send_sync();
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO - 1) tick();
    chk("p4_frame_drop_early", {30'd0, frame_drop_a, frame_drop_b}, 32'd0);
    tick();
    chk("p4_frame_drop_pulse", {30'd0, frame_drop_a, frame_drop_b}, 32'd3);
    tick();
    chk("p4_frame_drop_end", {30'd0, frame_drop_a, frame_drop_b}, 32'd0);
    repeat (5) tick();
    chk("p4_fd_count_a", fd_a - base_a, 32'd1);
    chk("p4_fd_count_b", fd_b - base_b, 32'd1);
    chk("p4_num_points_a", {21'd0, num_points_a}, 32'd6);
    chk("p4_num_points_b", {21'd0, num_points_b}, 32'd4);
    chk("p4_drawing", {30'd0, drawing_a, drawing_b}, 32'd3);

    // Reset mid-point, then a clean frame
    send_sync();
    send_byte(8'h2A);
    send_byte(8'hBC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("p5_reset");
    send_sync();
    send_word(32'h2ABCDEF0);
    send_word(32'h00000001);
    send_word(32'h01010101);
    tick();
    chk("p5_drawing", {30'd0, drawing_a, drawing_b}, 32'd3);
    chk("p5_num_points_a", {21'd0, num_points_a}, 32'd2);
    chk("p5_num_points_b", {21'd0, num_points_b}, 32'd2);
    run_reads(5);

    // Zero-point frame
    send_sync();
    send_word(32'h01010101);
    pulse_done();
    tick();
    chk("p6_drawing", {30'd0, drawing_a, drawing_b}, 32'd3);
    chk("p6_num_points_a", {21'd0, num_points_a}, 32'd0);
    chk("p6_num_points_b", {21'd0, num_points_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/point_frame_buffer.md
POINT_FRAME_BUFFER -- requirements
Module: point_frame_buffer

Interface
REQ-001 Parameter DEPTH, 2000, points per bank.
REQ-002 Parameter ADDR_W, 11, address/count width; 2^ADDR_W SHALL be greater than DEPTH.
REQ-003 Parameter COORD_W, 12, bits per axis.
REQ-004 Parameter BRIGHT_W, 6, brightness bits stored.
REQ-005 Parameter POINT_BYTES, 4, bytes per received point; 8*POINT_BYTES SHALL be at least DATA_W = 2*COORD_W+BRIGHT_W.
REQ-006 Parameter SYNC_LEN, 8, consecutive 0x00 bytes marking frame start (2..255).
REQ-007 Parameter TIMEOUT, 100000, idle clk cycles in RECV before the frame is aborted.
REQ-008 clk  in  1  clock; all logic on its rising edge.
REQ-009 reset  in  1  reset, synchronous, active-high.
REQ-010 in_valid  in  1  in_data holds a received byte this cycle.
REQ-011 in_data  in  8  received byte.
REQ-012 done_drawing  in  1  one-cycle pulse: renderer finished one pass of the read bank.
REQ-013 rd_addr  in  ADDR_W  read-bank address.
REQ-014 rd_point  out  DATA_W  registered read data: {brightness, x, y}.
REQ-015 num_points  out  ADDR_W  point count of the read bank.
REQ-016 drawing  out  1  read bank holds a frame handed to the renderer.
REQ-017 overflow  out  1  one-cycle pulse: point dropped because write bank was full.
REQ-018 frame_drop  out  1  one-cycle pulse: frame aborted by timeout.

Function
REQ-019 Two banks of DEPTH x DATA_W; wr_bank is written, the other is read; swapping SHALL exchange their roles.
REQ-020 rd_point SHALL equal read-bank[rd_addr] one cycle after rd_addr is presented; reads SHALL never return write-bank data.
REQ-021 States WAIT_SYNC, RECV, DONE; only in_valid cycles consume bytes.
REQ-022 WAIT_SYNC: 0x00 increments zero count, nonzero clears it; the SYNC_LEN-th consecutive zero SHALL enter RECV with wr_ptr=0, byte index=0, zero count=0.
REQ-023 RECV: bytes assemble MSB first into an 8*POINT_BYTES word; on the last byte the word is evaluated that same cycle.
REQ-024 Word with every byte 0x01 is the end marker: enter DONE, nothing written.
REQ-025 Otherwise, if wr_ptr < DEPTH: write word[DATA_W-1:0] to write-bank[wr_ptr] that cycle and increment wr_ptr; brightness = word[DATA_W-1:2*COORD_W], x = next COORD_W bits, y = low COORD_W bits.
REQ-026 If wr_ptr == DEPTH: drop the point, pulse overflow, stay in RECV until the end marker.
REQ-027 RECV: TIMEOUT consecutive cycles without in_valid SHALL pulse frame_drop and return to WAIT_SYNC; write bank and read side unchanged.
REQ-028 DONE: input bytes are discarded; when drawing==0, swap banks, load num_points with wr_ptr, set drawing=1, enter WAIT_SYNC, all in one cycle.
REQ-029 done_drawing while drawing==1 and state==DONE SHALL clear drawing next cycle; swap occurs the cycle after.
REQ-030 done_drawing in any other state SHALL leave drawing=1 (same frame redrawn); done_drawing with drawing==0 is ignored.
REQ-031 Zero-point frame (sync then end marker) SHALL swap with num_points=0.
REQ-032 num_points and read bank SHALL change only at a swap.

Reset
REQ-033 Reset SHALL force WAIT_SYNC, wr_bank=0, wr_ptr=0, zero count=0, byte index=0, timeout count=0, num_points=0, drawing=0, rd_point=0, overflow=0, frame_drop=0; bank contents undefined.
REQ-034 Reset mid-frame SHALL discard the partial frame; the next frame requires a full sync.

Verification
REQ-035 8x00, points 0x3F123456, 0x00ABCDEF, end 01010101 -> swap, num_points=2, drawing=1, rd_addr=0 gives 0x3F123456, rd_addr=1 gives 0x00ABCDEF (defaults).
REQ-036 7x00, 0x05, 8x00, one point, end -> only the second sync starts the frame; num_points=1.
REQ-037 Frame 2 fully received while drawing=1 -> no swap, rd_point unchanged; done_drawing pulse -> drawing=0, swap next cycle, num_points = frame 2 count.
REQ-038 DEPTH=4, six points then end -> two overflow pulses, num_points=4, entries 0..3 = first four points.
REQ-039 Sync, two bytes, TIMEOUT idle cycles -> frame_drop pulse, state WAIT_SYNC, num_points unchanged.
REQ-040 Reset asserted mid-point -> all outputs at REQ-033 values; subsequent valid frame received correctly.
